// File: rtl/map_pkg.sv
// Shared map geometry, tile codes and arbiter state encoding for the map
// RAM port-B write path.
package map_pkg;

    localparam int COLS   = 40;
    localparam int ROWS   = 32;
    localparam int TILE_W = 4;
    localparam int X_W    = 6;
    localparam int Y_W    = 5;

    localparam logic [TILE_W-1:0] TILE_EMPTY   = 4'd0;
    localparam logic [TILE_W-1:0] TILE_DOT     = 4'd1;
    localparam logic [TILE_W-1:0] TILE_PACMAN  = 4'd4;
    localparam logic [TILE_W-1:0] TILE_GHOST_1 = 4'd8;
    localparam logic [TILE_W-1:0] TILE_GHOST_2 = 4'd9;
    localparam logic [TILE_W-1:0] TILE_GHOST_3 = 4'd10;
    localparam logic [TILE_W-1:0] TILE_GHOST_4 = 4'd11;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_RD_CURR,
        ARB_WR_CURR,
        ARB_RD_NEXT,
        ARB_WR_NEXT,
        ARB_DONE_NOP
    } arb_state_t;

    // Column 0 is the most significant nibble of a row word.
    function automatic int cell_lsb(input int x, input int cols, input int tile_w);
        return (cols - 1 - x) * tile_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the search starts at the pointer, and the pointer moves
// one past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N = 5,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr_q;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance && grant_valid) begin
            if (int'(grant_idx) == N - 1) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/map_write_arbiter.sv
// Owns map RAM port B: serializes sprite moves as read-modify-write pairs
// (restore old cell, stamp new cell) and reports tiles eaten by consumers.
module map_write_arbiter #(
    parameter int                N_REQ    = 5,
    parameter int                COLS     = map_pkg::COLS,
    parameter int                TILE_W   = map_pkg::TILE_W,
    parameter logic [N_REQ-1:0]  EAT_MASK = 5'b00001
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [6*N_REQ-1:0]       curr_x,
    input  logic [5*N_REQ-1:0]       curr_y,
    input  logic [6*N_REQ-1:0]       next_x,
    input  logic [5*N_REQ-1:0]       next_y,
    input  logic [TILE_W*N_REQ-1:0]  tile_code,
    input  logic [COLS*TILE_W-1:0]   redata,
    output logic [N_REQ-1:0]         ack,
    output logic [4:0]               wraddr,
    output logic [COLS*TILE_W-1:0]   wrdata,
    output logic                     wren,
    output logic                     eaten_valid,
    output logic [TILE_W-1:0]        eaten_tile,
    output logic                     busy
);

    import map_pkg::*;

    localparam int ROW_W = COLS * TILE_W;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LSB_W = $clog2(ROW_W);

    logic [5:0]        cx_in   [N_REQ];
    logic [4:0]        cy_in   [N_REQ];
    logic [5:0]        nx_in   [N_REQ];
    logic [4:0]        ny_in   [N_REQ];
    logic [TILE_W-1:0] code_in [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign cx_in[gi]   = curr_x[6*gi +: 6];
        assign cy_in[gi]   = curr_y[5*gi +: 5];
        assign nx_in[gi]   = next_x[6*gi +: 6];
        assign ny_in[gi]   = next_y[5*gi +: 5];
        assign code_in[gi] = tile_code[TILE_W*gi +: TILE_W];
    end

    arb_state_t        state_q;
    logic [IDX_W-1:0]  sel_q;
    logic [5:0]        cx_q, nx_q;
    logic [4:0]        cy_q, ny_q;
    logic [TILE_W-1:0] code_q;
    logic [TILE_W-1:0] under_q [N_REQ];
    logic [4:0]        wraddr_q;
    logic              wren_q;
    logic [N_REQ-1:0]  ack_q;
    logic [ROW_W-1:0]  wrdata_q;

    logic [N_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic              arb_advance;

    assign arb_advance = (state_q == ARB_IDLE);

    rr_arbiter #(.N(N_REQ)) u_rr (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .req         (req),
        .advance     (arb_advance),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    logic [5:0]        w_cx, w_nx;
    logic [4:0]        w_cy, w_ny;
    logic              w_degen;

    assign w_cx    = cx_in[arb_idx];
    assign w_cy    = cy_in[arb_idx];
    assign w_nx    = nx_in[arb_idx];
    assign w_ny    = ny_in[arb_idx];
    assign w_degen = ((w_cx == w_nx) && (w_cy == w_ny))
                   || (int'(w_cx) >= COLS) || (int'(w_nx) >= COLS);

    logic [LSB_W-1:0]  curr_lsb_d, next_lsb_d;
    logic [TILE_W-1:0] old_nibble_d;
    logic [ROW_W-1:0]  wrdata_d;
    logic              in_write_d;
    logic              eat_hit_d;

    // Read data only arrives in the write cycle, so the patched word is
    // formed combinationally from redata; outside writes the last word is held.
    always_comb begin
        curr_lsb_d = '0;
        next_lsb_d = '0;
        if (int'(cx_q) < COLS) begin
            curr_lsb_d = LSB_W'(cell_lsb(int'(cx_q), COLS, TILE_W));
        end
        if (int'(nx_q) < COLS) begin
            next_lsb_d = LSB_W'(cell_lsb(int'(nx_q), COLS, TILE_W));
        end
        old_nibble_d = redata[next_lsb_d +: TILE_W];
        wrdata_d     = redata;
        in_write_d   = 1'b0;
        if (state_q == ARB_WR_CURR) begin
            in_write_d = 1'b1;
            wrdata_d[curr_lsb_d +: TILE_W] = EAT_MASK[sel_q] ? TILE_EMPTY : under_q[sel_q];
        end else if (state_q == ARB_WR_NEXT) begin
            in_write_d = 1'b1;
            wrdata_d[next_lsb_d +: TILE_W] = code_q;
        end
        eat_hit_d = (state_q == ARB_WR_NEXT) && EAT_MASK[sel_q]
                  && (old_nibble_d != TILE_EMPTY);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            sel_q    <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            nx_q     <= '0;
            ny_q     <= '0;
            code_q   <= TILE_EMPTY;
            wraddr_q <= '0;
            wren_q   <= 1'b0;
            ack_q    <= '0;
            wrdata_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                under_q[i] <= TILE_EMPTY;
            end
        end else begin
            ack_q  <= '0;
            wren_q <= 1'b0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (arb_valid) begin
                        sel_q  <= arb_idx;
                        cx_q   <= w_cx;
                        cy_q   <= w_cy;
                        nx_q   <= w_nx;
                        ny_q   <= w_ny;
                        code_q <= code_in[arb_idx];
                        if (w_degen) begin
                            state_q <= ARB_DONE_NOP;
                            ack_q   <= arb_grant;
                        end else begin
                            state_q  <= ARB_RD_CURR;
                            wraddr_q <= w_cy;
                        end
                    end
                end
                ARB_RD_CURR: begin
                    state_q <= ARB_WR_CURR;
                    wren_q  <= 1'b1;
                end
                ARB_WR_CURR: begin
                    state_q  <= ARB_RD_NEXT;
                    wrdata_q <= wrdata_d;
                    wraddr_q <= ny_q;
                end
                ARB_RD_NEXT: begin
                    state_q <= ARB_WR_NEXT;
                    wren_q  <= 1'b1;
                    ack_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_q;
                end
                ARB_WR_NEXT: begin
                    state_q        <= ARB_IDLE;
                    wrdata_q       <= wrdata_d;
                    under_q[sel_q] <= old_nibble_d;
                end
                ARB_DONE_NOP: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign wren        = wren_q;
    assign wraddr      = wraddr_q;
    assign wrdata      = in_write_d ? wrdata_d : wrdata_q;
    assign eaten_valid = eat_hit_d;
    assign eaten_tile  = eat_hit_d ? old_nibble_d : TILE_EMPTY;
    assign busy        = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed and randomized moves against a cell-level map model with a
// behavioural port-B RAM; checks ack order/latency, eaten reports and map state.
module tb_map_write_arbiter;
    import map_pkg::*;

    localparam logic [4:0] EAT = 5'b00001;

    logic         CLOCK_50 = 1'b0;
    logic         reset;
    logic [4:0]   req;
    logic [29:0]  curr_x, next_x;
    logic [24:0]  curr_y, next_y;
    logic [19:0]  tile_code;
    logic [159:0] redata;
    logic [4:0]   ack;
    logic [4:0]   wraddr;
    logic [159:0] wrdata;
    logic         wren;
    logic         eaten_valid;
    logic [3:0]   eaten_tile;
    logic         busy;

    map_write_arbiter dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .req         (req),
        .curr_x      (curr_x),
        .curr_y      (curr_y),
        .next_x      (next_x),
        .next_y      (next_y),
        .tile_code   (tile_code),
        .redata      (redata),
        .ack         (ack),
        .wraddr      (wraddr),
        .wrdata      (wrdata),
        .wren        (wren),
        .eaten_valid (eaten_valid),
        .eaten_tile  (eaten_tile),
        .busy        (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int         mv_cx [5];
    int         mv_cy [5];
    int         mv_nx [5];
    int         mv_ny [5];
    logic [3:0] mv_code [5];

    always_comb begin
        curr_x = '0; curr_y = '0; next_x = '0; next_y = '0; tile_code = '0;
        for (int i = 0; i < 5; i++) begin
            curr_x[6*i +: 6]    = 6'(mv_cx[i]);
            curr_y[5*i +: 5]    = 5'(mv_cy[i]);
            next_x[6*i +: 6]    = 6'(mv_nx[i]);
            next_y[5*i +: 5]    = 5'(mv_ny[i]);
            tile_code[4*i +: 4] = mv_code[i];
        end
    end

    // Port-B RAM with a bench-side loader port used only while the DUT is idle.
    logic [159:0] mem [32];
    logic         tb_we;
    logic [4:0]   tb_addr;
    logic [159:0] tb_data;

    always @(posedge CLOCK_50) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (wren) mem[wraddr] <= wrdata;
        redata <= mem[wraddr];
    end

    int cyc = 0;
    int wren_cnt = 0;
    always @(posedge CLOCK_50) begin
        cyc <= cyc + 1;
        if (wren === 1'b1) wren_cnt <= wren_cnt + 1;
    end

    logic [3:0] mmap [32][40];
    logic [3:0] mund [5];
    int         mptr;
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic logic [159:0] pack_row(input int y);
        logic [159:0] r;
        r = '0;
        for (int x = 0; x < 40; x++) r[159 - 4*x -: 4] = mmap[y][x];
        return r;
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_map();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 40; x++) mmap[y][x] = TILE_EMPTY;
    endtask

    task automatic random_map();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 40; x++) mmap[y][x] = 4'($urandom_range(0, 15));
    endtask

    task automatic push_map();
        for (int y = 0; y < 32; y++) begin
            @(negedge CLOCK_50);
            tb_we = 1'b1; tb_addr = 5'(y); tb_data = pack_row(y);
        end
        @(negedge CLOCK_50);
        tb_we = 1'b0;
    endtask

    task automatic set_move(input int r, input int cx, input int cy, input int nx, input int ny,
                            input logic [3:0] code);
        mv_cx[r] = cx; mv_cy[r] = cy; mv_nx[r] = nx; mv_ny[r] = ny; mv_code[r] = code;
    endtask

    task automatic run_group(input logic [4:0] mask);
        logic [4:0] pend;
        int start, extra, w, lat, got, wr0, exp_wr, bad, first_bad;
        logic degen, exp_eat;
        logic [3:0] old;
        pend = mask; extra = 0; exp_wr = 0; old = '0;
        @(negedge CLOCK_50);
        check("busy_before_req", 160'(busy), 160'(0));
        req = mask; start = cyc; wr0 = wren_cnt;
        while (pend != 0) begin
            w = -1;
            for (int k = 0; k < 5; k++) begin
                int i;
                i = (mptr + k) % 5;
                if (w < 0 && pend[i]) w = i;
            end
            degen = ((mv_cx[w] == mv_nx[w]) && (mv_cy[w] == mv_ny[w]))
                  || (mv_cx[w] >= 40) || (mv_nx[w] >= 40);
            lat = (degen ? 1 : 4) + extra;
            got = 0;
            for (int k = 0; k < 20 && got == 0; k++) begin
                @(negedge CLOCK_50);
                if (ack !== 5'b0) got = 1;
            end
            n_cmp++;
            assert (got == 1) else begin
                n_bad++;
                $error("FAIL ack_timeout: observed=no ack expected=ack[%0d]", w);
            end
            if (got == 0) begin
                req = '0;
                return;
            end
            check("ack_onehot", 160'(ack), 160'(5'b1 << w));
            check("ack_latency", 160'(cyc - start), 160'(lat));
            exp_eat = 1'b0;
            if (!degen) begin
                mmap[mv_cy[w]][mv_cx[w]] = EAT[w] ? TILE_EMPTY : mund[w];
                old = mmap[mv_ny[w]][mv_nx[w]];
                mmap[mv_ny[w]][mv_nx[w]] = mv_code[w];
                mund[w] = old;
                exp_eat = EAT[w] && (old != TILE_EMPTY);
                exp_wr += 2;
            end
            check("eaten_valid", 160'(eaten_valid), 160'(exp_eat));
            if (exp_eat) check("eaten_tile", 160'(eaten_tile), 160'(old));
            $display("move req%0d (%0d,%0d)->(%0d,%0d) code=%0d ack_after=%0d nop=%0d eaten=%0d",
                     w, mv_cx[w], mv_cy[w], mv_nx[w], mv_ny[w], mv_code[w], cyc - start,
                     degen, eaten_valid);
            req[w] = 1'b0; pend[w] = 1'b0; mptr = (w + 1) % 5; start = cyc; extra = 1;
        end
        @(negedge CLOCK_50);
        check("wren_count", 160'(wren_cnt - wr0), 160'(exp_wr));
        bad = 0; first_bad = 0;
        for (int y = 0; y < 32; y++) begin
            if (mem[y] !== pack_row(y)) begin
                if (bad == 0) first_bad = y;
                bad++;
            end
        end
        n_cmp++;
        assert (bad == 0) else begin
            n_bad++;
            $error("FAIL map_rows: observed=%0d bad rows (first row %0d = %0h) expected=0 (row = %0h)",
                   bad, first_bad, mem[first_bad], pack_row(first_bad));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req = '0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        for (int i = 0; i < 5; i++) begin
            set_move(i, 0, 0, 0, 0, TILE_EMPTY);
            mund[i] = TILE_EMPTY;
        end
        mptr = 0;
        repeat (4) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("rst_ack", 160'(ack), 160'(0));
        check("rst_wren", 160'(wren), 160'(0));
        check("rst_wraddr", 160'(wraddr), 160'(0));
        check("rst_wrdata", wrdata, 160'(0));
        check("rst_eaten_valid", 160'(eaten_valid), 160'(0));
        check("rst_eaten_tile", 160'(eaten_tile), 160'(0));
        check("rst_busy", 160'(busy), 160'(0));

        // Pacman eats a dot while ghost 2 waits its turn.
        clear_map();
        mmap[1][1] = TILE_PACMAN; mmap[1][2] = TILE_DOT; mmap[10][21] = 4'd2;
        push_map();
        set_move(0, 1, 1, 2, 1, TILE_PACMAN);
        set_move(2, 20, 10, 21, 10, TILE_GHOST_2);
        run_group(5'b00101);

        // Ghost 1 steps onto a dot, then off it again.
        mmap[3][5] = TILE_GHOST_1; mmap[4][5] = TILE_DOT;
        push_map();
        set_move(1, 5, 3, 5, 4, TILE_GHOST_1);
        run_group(5'b00010);
        set_move(1, 5, 4, 5, 5, TILE_GHOST_1);
        run_group(5'b00010);

        // Tie between requesters 1 and 4 resolved from the current pointer.
        set_move(1, 5, 5, 6, 5, TILE_GHOST_1);
        set_move(4, 30, 20, 31, 20, TILE_GHOST_4);
        run_group(5'b10010);

        // Degenerate moves complete without touching the map.
        set_move(3, 3, 3, 3, 3, TILE_GHOST_3);
        run_group(5'b01000);
        set_move(3, 3, 3, 40, 3, TILE_GHOST_3);
        run_group(5'b01000);

        // Same-row move over a random row.
        for (int x = 0; x < 40; x++) mmap[7][x] = 4'($urandom_range(0, 15));
        push_map();
        set_move(3, 10, 7, 9, 7, TILE_GHOST_3);
        run_group(5'b01000);

        // Reset while the first write of a move is on the bus.
        set_move(2, 12, 15, 13, 15, TILE_GHOST_2);
        @(negedge CLOCK_50);
        req = 5'b00100;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("midop_wren_before_reset", 160'(wren), 160'(1));
        reset = 1'b1; req = '0;
        @(negedge CLOCK_50);
        check("midop_wren", 160'(wren), 160'(0));
        check("midop_ack", 160'(ack), 160'(0));
        check("midop_busy", 160'(busy), 160'(0));
        reset = 1'b0;
        for (int i = 0; i < 5; i++) mund[i] = TILE_EMPTY;
        mptr = 0;
        random_map();
        mmap[15][12] = TILE_GHOST_2;
        push_map();
        run_group(5'b00100);

        // Randomized groups of simultaneous requests.
        random_map();
        push_map();
        for (int g = 0; g < 30; g++) begin
            logic [4:0] mask;
            mask = 5'($urandom_range(1, 31));
            for (int i = 0; i < 5; i++) begin
                int r, cx, cy, nx, ny;
                r  = $urandom_range(0, 9);
                cx = $urandom_range(0, 39);
                cy = $urandom_range(0, 31);
                nx = $urandom_range(0, 39);
                ny = $urandom_range(0, 31);
                if (r == 0) begin nx = cx; ny = cy; end
                else if (r == 1) nx = $urandom_range(40, 63);
                else if (r == 2) cx = $urandom_range(40, 63);
                else if (r == 3) ny = cy;
                set_move(i, cx, cy, nx, ny, 4'($urandom_range(1, 15)));
            end
            run_group(mask);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
